// File: rtl/rand_pkg.sv
// Shared definitions for the random-number arbiter: LFSR constants, FSM state
// encoding and the single-step LFSR transition.
package rand_pkg;

  localparam int          LFSR_W       = 64;
  localparam logic [63:0] LFSR_POLY    = 64'h1B;
  localparam logic [63:0] DEFAULT_SEED = 64'h0c45f864_04e4684a;

  typedef enum logic [1:0] {
    ST_SERVE  = 2'd0,
    ST_RESEED = 2'd1,
    ST_WARM   = 2'd2
  } arb_state_t;

  // Galois form: shift left, fold the outgoing MSB back through the taps.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
    return {v[LFSR_W-2:0], 1'b0} ^ (v[LFSR_W-1] ? LFSR_POLY : '0);
  endfunction

endpackage

// File: rtl/rand_arb_if.sv
// Request/ack/data bundle between requesters and the random arbiter, plus the
// reseed controls.
interface rand_arb_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] ack;
  logic [WIDTH-1:0]   rand_data;
  logic               seed_load;
  logic [63:0]        seed_value;
  logic               busy;

  modport master (
    output req, seed_load, seed_value,
    input  ack, rand_data, busy
  );

  modport slave (
    input  req, seed_load, seed_value,
    output ack, rand_data, busy
  );
endinterface

// File: rtl/rand_lfsr.sv
// 64-bit Galois LFSR register with synchronous load and advance enable; load
// wins over advance. Exposes only the low WIDTH bits consumers need.
module rand_lfsr
  import rand_pkg::*;
#(
  parameter int          WIDTH = 32,
  parameter logic [63:0] SEED  = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_load,
  input  logic [LFSR_W-1:0] i_load_value,
  input  logic              i_advance,
  output logic [WIDTH-1:0]  o_word
);

  logic [LFSR_W-1:0] r_lfsr;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lfsr <= SEED;
    end else if (i_load) begin
      r_lfsr <= i_load_value;
    end else if (i_advance) begin
      r_lfsr <= lfsr_step(r_lfsr);
    end
  end

  assign o_word = r_lfsr[WIDTH-1:0];

endmodule

// File: rtl/rand_arb.sv
// Round-robin arbiter handing out LFSR words: one grant per cycle in SERVE,
// reseed and warm-up sequencing in RESEED/WARM with busy raised.
module rand_arb
  import rand_pkg::*;
#(
  parameter int          NUM_REQ = 4,
  parameter int          WIDTH   = 32,
  parameter int          WARMUP  = 8,
  parameter logic [63:0] SEED    = DEFAULT_SEED
) (
  input  logic       clk,
  input  logic       reset_n,
  rand_arb_if.slave  bus
);

  localparam int                PTR_W     = $clog2(NUM_REQ);
  localparam logic [PTR_W:0]    NUM_REQ_W = (PTR_W+1)'(NUM_REQ);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(NUM_REQ - 1);
  localparam logic [7:0]        WARM_LAST = 8'(WARMUP - 1);

  arb_state_t          r_state;
  logic [PTR_W-1:0]    r_ptr;
  logic [NUM_REQ-1:0]  r_ack;
  logic [WIDTH-1:0]    r_rand_data;
  logic                r_busy;
  logic [7:0]          r_warm_cnt;
  logic [LFSR_W-1:0]   r_seed;

  logic [WIDTH-1:0]    w_word;
  logic [NUM_REQ-1:0]  w_elig;
  logic                w_serve;
  logic                w_grant_vld;
  logic [PTR_W-1:0]    w_grant_idx;
  logic [PTR_W:0]      w_sum;
  logic                w_lfsr_load;
  logic                w_lfsr_adv;
  logic [LFSR_W-1:0]   w_seed_pick;

  // An all-zero seed would lock the LFSR, so it falls back to the reset seed.
  assign w_seed_pick = (bus.seed_value == '0) ? SEED : bus.seed_value;
  assign w_elig      = bus.req & ~r_ack;
  assign w_serve     = (r_state == ST_SERVE) && !bus.seed_load;
  assign w_lfsr_load = (r_state == ST_RESEED) && !bus.seed_load;
  assign w_lfsr_adv  = w_grant_vld || ((r_state == ST_WARM) && !bus.seed_load);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and a latch cannot be inferred.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = r_ptr;
    w_sum       = '0;
    if (w_serve) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        w_sum = {1'b0, r_ptr} + (PTR_W+1)'(k);
        if (w_sum >= NUM_REQ_W) w_sum = w_sum - NUM_REQ_W;
        if (!w_grant_vld && w_elig[w_sum[PTR_W-1:0]]) begin
          w_grant_vld = 1'b1;
          w_grant_idx = w_sum[PTR_W-1:0];
        end
      end
    end
  end

  rand_lfsr #(
    .WIDTH (WIDTH),
    .SEED  (SEED)
  ) u_lfsr (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_load       (w_lfsr_load),
    .i_load_value (r_seed),
    .i_advance    (w_lfsr_adv),
    .o_word       (w_word)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_SERVE;
      r_ptr       <= PTR_LAST;
      r_ack       <= '0;
      r_rand_data <= '0;
      r_busy      <= 1'b0;
      r_warm_cnt  <= '0;
      r_seed      <= SEED;
    end else begin
      r_ack <= '0;
      if (bus.seed_load) begin
        // Reseed preempts any grant this cycle and restarts an ongoing reseed.
        r_state <= ST_RESEED;
        r_seed  <= w_seed_pick;
        r_busy  <= 1'b1;
      end else begin
        case (r_state)
          ST_SERVE: begin
            if (w_grant_vld) begin
              r_ack       <= NUM_REQ'(1) << w_grant_idx;
              r_rand_data <= w_word;
              r_ptr       <= w_grant_idx;
            end
          end
          ST_RESEED: begin
            r_state    <= ST_WARM;
            r_warm_cnt <= '0;
            r_busy     <= 1'b1;
          end
          ST_WARM: begin
            if (r_warm_cnt == WARM_LAST) begin
              r_state <= ST_SERVE;
              r_busy  <= 1'b0;
            end else begin
              r_warm_cnt <= r_warm_cnt + 8'd1;
            end
          end
          default: begin
            r_state <= ST_SERVE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.ack       = r_ack;
  assign bus.rand_data = r_rand_data;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_rand_arb.sv
// Self-checking bench for rand_arb: a table of per-cycle vectors plus directed
// sequences for reseed restart, WARMUP=1 reseed and reset during warm-up.
module tb_rand_arb;

  localparam logic [63:0] SEED = 64'h0c45f864_04e4684a;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  rand_arb_if #(.NUM_REQ(4), .WIDTH(32)) bus ();
  rand_arb_if #(.NUM_REQ(4), .WIDTH(32)) bus2 ();

  rand_arb dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  rand_arb #(.WARMUP(1)) dut_w1 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus2)
  );

  typedef struct {
    bit          rst;
    logic [3:0]  req;
    logic        sl;
    logic [63:0] sv;
    logic [3:0]  ack;
    logic [31:0] data;
    logic        busy;
  } vec_t;

  vec_t        vecs[$];
  logic [63:0] s[0:15];
  logic [31:0] w[0:15];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cnt;

  function automatic logic [63:0] nxt(input logic [63:0] v);
    logic [63:0] r;
    r = {v[62:0], 1'b0};
    if (v[63]) r = r ^ 64'h1B;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic add(input bit rst, input logic [3:0] req, input logic sl,
                     input logic [63:0] sv, input logic [3:0] ack,
                     input logic [31:0] data, input logic busy);
    vec_t v;
    v.rst = rst; v.req = req; v.sl = sl; v.sv = sv;
    v.ack = ack; v.data = data; v.busy = busy;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.req  = '0; bus.seed_load  = 1'b0; bus.seed_value  = '0;
    bus2.req = '0; bus2.seed_load = 1'b0; bus2.seed_value = '0;

    s[0] = SEED;
    for (int i = 1; i < 16; i++) s[i] = nxt(s[i-1]);
    for (int i = 0; i < 16; i++) w[i] = s[i][31:0];

    // Single requester: ack every second cycle, consecutive words.
    add(1, 4'b0000, 0, 0, 4'b0000, 32'h0, 0);
    add(0, 4'b0001, 0, 0, 4'b0001, w[0], 0);
    add(0, 4'b0001, 0, 0, 4'b0000, w[0], 0);
    add(0, 4'b0001, 0, 0, 4'b0001, w[1], 0);
    add(0, 4'b0001, 0, 0, 4'b0000, w[1], 0);
    add(0, 4'b0001, 0, 0, 4'b0001, w[2], 0);
    add(0, 4'b0000, 0, 0, 4'b0000, w[2], 0);
    // All four requesting: 0,1,2,3,0 back to back.
    add(1, 4'b0000, 0, 0, 4'b0000, 32'h0, 0);
    add(0, 4'b1111, 0, 0, 4'b0001, w[0], 0);
    add(0, 4'b1111, 0, 0, 4'b0010, w[1], 0);
    add(0, 4'b1111, 0, 0, 4'b0100, w[2], 0);
    add(0, 4'b1111, 0, 0, 4'b1000, w[3], 0);
    add(0, 4'b1111, 0, 0, 4'b0001, w[4], 0);
    add(0, 4'b0000, 0, 0, 4'b0000, w[4], 0);
    // Zero seed: falls back to SEED, first word is 8 advances in.
    add(0, 4'b0000, 1, 0, 4'b0000, w[4], 1);
    add(0, 4'b0010, 0, 0, 4'b0000, w[4], 1);
    for (int k = 1; k <= 8; k++) add(0, 4'b0010, 0, 0, 4'b0000, w[4], (k < 8));
    add(0, 4'b0010, 0, 0, 4'b0010, w[8], 0);
    add(0, 4'b0010, 0, 0, 4'b0000, w[8], 0);
    add(0, 4'b0010, 0, 0, 4'b0010, w[9], 0);
    add(0, 4'b0000, 0, 0, 4'b0000, w[9], 0);
    // Reseed colliding with a grant to requester 2; 2 wins after busy falls.
    add(1, 4'b0000, 0, 0, 4'b0000, 32'h0, 0);
    add(0, 4'b0010, 0, 0, 4'b0010, w[0], 0);
    add(0, 4'b0100, 1, 0, 4'b0000, w[0], 1);
    add(0, 4'b0100, 0, 0, 4'b0000, w[0], 1);
    for (int k = 1; k <= 8; k++) add(0, 4'b0100, 0, 0, 4'b0000, w[0], (k < 8));
    add(0, 4'b0110, 0, 0, 4'b0100, w[8], 0);
    add(0, 4'b0110, 0, 0, 4'b0010, w[9], 0);
    add(0, 4'b0000, 0, 0, 4'b0000, w[9], 0);

    foreach (vecs[i]) begin
      if (vecs[i].rst) begin
        reset_n = 1'b0;
        bus.req = '0; bus.seed_load = 1'b0; bus.seed_value = '0;
        step();
        check($sformatf("v%0d reset ack", i),  {60'h0, bus.ack}, 64'h0);
        check($sformatf("v%0d reset data", i), {32'h0, bus.rand_data}, 64'h0);
        check($sformatf("v%0d reset busy", i), {63'h0, bus.busy}, 64'h0);
        reset_n = 1'b1;
      end else begin
        bus.req        = vecs[i].req;
        bus.seed_load  = vecs[i].sl;
        bus.seed_value = vecs[i].sv;
        step();
        check($sformatf("v%0d ack", i),  {60'h0, bus.ack}, {60'h0, vecs[i].ack});
        check($sformatf("v%0d data", i), {32'h0, bus.rand_data}, {32'h0, vecs[i].data});
        check($sformatf("v%0d busy", i), {63'h0, bus.busy}, {63'h0, vecs[i].busy});
      end
    end
    bus.seed_load = 1'b0;
    bus.req = '0;

    // Second reseed in the middle of warm-up restarts with the new value.
    bus.seed_load = 1'b1; bus.seed_value = 64'h1234_5678_9abc_def0;
    step();
    bus.seed_load = 1'b0;
    repeat (4) step();
    bus.seed_load = 1'b1; bus.seed_value = 64'h8000_0000_0000_0000;
    step();
    bus.seed_load = 1'b0;
    check("restart busy", {63'h0, bus.busy}, 64'h1);
    cnt = 1;
    for (int k = 0; k < 40 && bus.busy; k++) begin
      step();
      if (bus.busy) cnt++;
    end
    check("restart busy cycles", 64'(cnt), 64'd9);
    bus.req = 4'b0001;
    step();
    check("restart ack", {60'h0, bus.ack}, 64'h1);
    check("restart data", {32'h0, bus.rand_data}, 64'h0000_0D80);
    bus.req = '0;
    step();

    // WARMUP=1 instance: MSB-only seed gives 0x1B after one advance.
    bus2.seed_load = 1'b1; bus2.seed_value = 64'h8000_0000_0000_0000;
    step();
    bus2.seed_load = 1'b0;
    cnt = 0;
    for (int k = 0; k < 40 && bus2.busy; k++) begin
      cnt++;
      step();
    end
    check("w1 busy cycles", 64'(cnt), 64'd2);
    bus2.req = 4'b0001;
    step();
    check("w1 ack", {60'h0, bus2.ack}, 64'h1);
    check("w1 data", {32'h0, bus2.rand_data}, 64'h0000_001B);
    bus2.req = '0;

    // Asynchronous reset in the middle of warm-up with a request pending.
    bus.req = 4'b0010; bus.seed_load = 1'b1; bus.seed_value = '0;
    step();
    bus.seed_load = 1'b0;
    repeat (3) step();
    check("pre-reset busy", {63'h0, bus.busy}, 64'h1);
    check("pre-reset data", {32'h0, bus.rand_data}, 64'h0000_0D80);
    #2 reset_n = 1'b0;
    #1;
    check("async reset ack", {60'h0, bus.ack}, 64'h0);
    check("async reset data", {32'h0, bus.rand_data}, 64'h0);
    check("async reset busy", {63'h0, bus.busy}, 64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    check("post-reset ack", {60'h0, bus.ack}, 64'h2);
    check("post-reset data", {32'h0, bus.rand_data}, {32'h0, 32'h04e4684a});
    bus.req = '0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
